fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit WISC pipeline.
- Holds the PC and issues reads to the instruction memory system (stall/done handshake).
- Applies redirects for branch, jump, SIIC and RTI, and presents the fetched instruction to the instruction decoder, whose 5-bit opcode is instr[15:11].
- Owns the EPC register, holds on hazard stalls, injects NOP bubbles, and stops fetching on HALT.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/dff.sv | 17 +
 rtl/fetch_next_pc.sv | 33 +++
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, fetch FSM encoding and PC helpers for the WISC fetch stage.
package fetch_stage_pkg;

  localparam logic [15:0] DEF_RESET_PC    = 16'h0000;
  localparam logic [15:0] DEF_SIIC_VECTOR = 16'h0002;
  localparam logic [15:0] DEF_NOP_INSTR   = 16'h0800;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    WAIT_MEM = 2'b01,
    HALTED   = 2'b10
  } fetch_state_e;

  // Instructions are halfword aligned, so bit 0 of any fetch target is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/dff.sv
// Plain W-bit register with synchronous active-high reset to RST_VAL.
module dff #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) q_o <= RST_VAL;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/fetch_next_pc.sv
// Redirect priority mux: picks the fetch target (RTI > SIIC > branch/jump) and
// reports whether IF/ID must be flushed this cycle.
module fetch_next_pc
  import fetch_stage_pkg::*;
(
  input  logic [15:0] pc_i,
  input  logic [15:0] epc_i,
  input  logic [15:0] redirect_pc_i,
  input  logic [15:0] siic_vector_i,
  input  logic        rti_i,
  input  logic        siic_i,
  input  logic        redirect_i,
  output logic        flush_o,
  output logic        siic_sel_o,
  output logic [15:0] target_o,
  output logic [15:0] pc_plus2_o
);

  always_comb begin
    target_o   = align_pc(redirect_pc_i);
    siic_sel_o = 1'b0;
    if (rti_i) begin
      target_o = align_pc(epc_i);
    end else if (siic_i) begin
      target_o   = align_pc(siic_vector_i);
      siic_sel_o = 1'b1;
    end
  end

  assign flush_o    = rti_i | siic_i | redirect_i;
  assign pc_plus2_o = pc_i + 16'd2;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction fetch: PC/EPC, imem handshake FSM, one-entry skid buffer for
// fetches that complete under a hazard stall, and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [15:0] SIIC_VECTOR = DEF_SIIC_VECTOR,
  parameter logic [15:0] NOP_INSTR   = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        siic_take,
  input  logic [15:0] siic_pc_plus2,
  input  logic        rti_take,
  input  logic        halt_in,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        fetch_halted
);

  fetch_state_e state_q, state_d;
  logic         halted_q, halted_d;
  logic [15:0]  pc_q, pc_d, epc_q, epc_d;
  logic [15:0]  ifid_instr_q, ifid_instr_d, ifid_pc2_q, ifid_pc2_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         pend_valid_q, pend_valid_d;
  logic [15:0]  pend_pc_q, pend_pc_d;
  logic         skid_valid_q, skid_valid_d;
  logic [15:0]  skid_instr_q, skid_instr_d;

  logic         flush, siic_sel;
  logic [15:0]  target, pc_plus2;
  logic         mem_req, mem_accept;
  logic         load, bubble;
  logic [15:0]  load_instr;

  fetch_next_pc u_next_pc (
    .pc_i         (pc_q),
    .epc_i        (epc_q),
    .redirect_pc_i(redirect_pc),
    .siic_vector_i(SIIC_VECTOR),
    .rti_i        (rti_take),
    .siic_i       (siic_take),
    .redirect_i   (redirect_valid),
    .flush_o      (flush),
    .siic_sel_o   (siic_sel),
    .target_o     (target),
    .pc_plus2_o   (pc_plus2)
  );

  // No new request while a skid entry waits to drain; it is pc's instruction.
  assign mem_req    = (state_q == RUN) && !stall_id && !halt_in && !skid_valid_q;
  assign mem_accept = mem_req && !imem_stall;

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc2_d   = ifid_pc2_q;
    ifid_valid_d = ifid_valid_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    load         = 1'b0;
    bubble       = 1'b0;
    load_instr   = imem_data;

    if (state_q != HALTED && siic_sel) epc_d = siic_pc_plus2;

    unique case (state_q)
      RUN: begin
        if (flush) begin
          bubble       = 1'b1;
          skid_valid_d = 1'b0;
          // An accepted miss still has to drain; remember where to go afterwards.
          if (mem_accept && !imem_done) begin
            state_d      = WAIT_MEM;
            pend_valid_d = 1'b1;
            pend_pc_d    = target;
          end else begin
            pc_d = target;
          end
        end else if (halt_in) begin
          state_d      = HALTED;
          halted_d     = 1'b1;
          bubble       = 1'b1;
          skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
          if (!stall_id) begin
            load         = 1'b1;
            load_instr   = skid_instr_q;
            skid_valid_d = 1'b0;
          end
        end else if (mem_req && imem_done) begin
          load = 1'b1;
        end else begin
          if (mem_accept) state_d = WAIT_MEM;
          bubble = !stall_id;
        end
      end
      WAIT_MEM: begin
        if (halt_in && !flush) begin
          state_d      = HALTED;
          halted_d     = 1'b1;
          bubble       = 1'b1;
          pend_valid_d = 1'b0;
        end else if (imem_done) begin
          state_d      = RUN;
          pend_valid_d = 1'b0;
          if (flush || pend_valid_q) begin
            pc_d   = flush ? target : pend_pc_q;
            bubble = flush || !stall_id;
          end else if (stall_id) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_data;
          end else begin
            load = 1'b1;
          end
        end else begin
          if (flush) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = target;
          end
          bubble = flush || !stall_id;
        end
      end
      HALTED: bubble = 1'b1;
      default: state_d = RUN;
    endcase

    if (load) begin
      ifid_instr_d = load_instr;
      ifid_pc2_d   = pc_plus2;
      ifid_valid_d = 1'b1;
      pc_d         = pc_plus2;
    end else if (bubble) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  // ---- state / IF-ID register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  dff #(.W(16), .RST_VAL(RESET_PC))  u_pc    (.clk(clk), .rst(rst), .d_i(pc_d),         .q_o(pc_q));
  dff #(.W(16), .RST_VAL(16'h0000))  u_epc   (.clk(clk), .rst(rst), .d_i(epc_d),        .q_o(epc_q));
  dff #(.W(16), .RST_VAL(NOP_INSTR)) u_ifi   (.clk(clk), .rst(rst), .d_i(ifid_instr_d), .q_o(ifid_instr_q));
  dff #(.W(16), .RST_VAL(16'h0000))  u_ifp   (.clk(clk), .rst(rst), .d_i(ifid_pc2_d),   .q_o(ifid_pc2_q));
  dff #(.W(1),  .RST_VAL(1'b0))      u_ifv   (.clk(clk), .rst(rst), .d_i(ifid_valid_d), .q_o(ifid_valid_q));
  dff #(.W(1),  .RST_VAL(1'b0))      u_pendv (.clk(clk), .rst(rst), .d_i(pend_valid_d), .q_o(pend_valid_q));
  dff #(.W(16), .RST_VAL(16'h0000))  u_pendp (.clk(clk), .rst(rst), .d_i(pend_pc_d),    .q_o(pend_pc_q));
  dff #(.W(1),  .RST_VAL(1'b0))      u_skidv (.clk(clk), .rst(rst), .d_i(skid_valid_d), .q_o(skid_valid_q));
  dff #(.W(16), .RST_VAL(16'h0000))  u_skidd (.clk(clk), .rst(rst), .d_i(skid_instr_d), .q_o(skid_instr_q));

  assign imem_rd       = mem_req && !rst;
  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus2 = ifid_pc2_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_halted  = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-randomising memory model plus directed scenarios
// and a random scoreboard of the architectural fetch stream.
module tb_fetch_stage;

  localparam logic [15:0] NOP  = 16'h0800;
  localparam logic [15:0] SIIC = 16'h0002;

  logic clk = 1'b0;
  logic rst, stall_id, redirect_valid, siic_take, rti_take, halt_in;
  logic [15:0] redirect_pc, siic_pc_plus2, imem_data;
  logic imem_stall, imem_done;
  logic imem_rd, ifid_valid, fetch_halted;
  logic [15:0] imem_addr, ifid_instr, ifid_pc_plus2;

  int checks = 0;
  int failures = 0;

  // memory model state
  logic mbusy = 1'b0;
  logic acc_now = 1'b0;
  int mcnt = 0;
  int mlat = 0;
  int lat_fix = 0;
  logic [15:0] maddr = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .siic_take(siic_take), .siic_pc_plus2(siic_pc_plus2),
    .rti_take(rti_take), .halt_in(halt_in), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_stall(imem_stall), .imem_done(imem_done),
    .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid),
    .fetch_halted(fetch_halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h2F1B;
    return m ^ 16'h4001;
  endfunction

  task automatic mem_pre();
    imem_done = 1'b0;
    imem_data = 16'($urandom);
    acc_now   = 1'b0;
    if (mbusy) begin
      if (mcnt == 1) begin imem_done = 1'b1; imem_data = mem_word(maddr); end
    end else if (imem_rd && !imem_stall) begin
      maddr   = imem_addr;
      acc_now = 1'b1;
      mlat    = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      if (mlat == 0) begin imem_done = 1'b1; imem_data = mem_word(maddr); end
    end
  endtask

  task automatic mem_post();
    if (imem_done) mbusy = 1'b0;
    else if (mbusy) mcnt--;
    else if (acc_now) begin mbusy = 1'b1; mcnt = mlat; end
  endtask

  task automatic step();
    #1;
    mem_pre();
    @(posedge clk);
    mem_post();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall_id = 0; redirect_valid = 0; redirect_pc = 0; siic_take = 0;
    siic_pc_plus2 = 0; rti_take = 0; halt_in = 0; imem_stall = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mbusy = 1'b0;
    imem_done = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", imem_rd); end
    step(); step();
    rst = 1'b0; mbusy = 1'b0;
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", imem_addr); end
    checks++; if (ifid_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, NOP); end
    checks++; if (ifid_pc_plus2 !== 16'h0000 || ifid_valid !== 1'b0 || fetch_halted !== 1'b0) begin
      failures++; $display("FAIL reset_ctl got=%h/%b/%b exp=0000/0/0", ifid_pc_plus2, ifid_valid, fetch_halted); end
    #1;
    checks++; if (imem_rd !== 1'b1) begin failures++; $display("FAIL reset_rd_after got=%b exp=1", imem_rd); end
  endtask

  task automatic test_sequential();
    do_reset(); lat_fix = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus2 !== 16'(2*k) || ifid_instr !== mem_word(16'(2*k-2))) begin
        failures++; $display("FAIL seq_ifid%0d got=%h/%h/%b exp=%h/%h/1", k, ifid_instr, ifid_pc_plus2, ifid_valid, mem_word(16'(2*k-2)), 16'(2*k)); end
      checks++; if (imem_addr !== 16'(2*k)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", k, imem_addr, 16'(2*k)); end
    end
  endtask

  task automatic test_miss();
    do_reset();
    stall_id = 1; redirect_valid = 1; redirect_pc = 16'h0010;
    step();
    clear_inputs(); lat_fix = 3;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL miss_bubble%0d got=%b exp=0", k, ifid_valid); end
    end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== mem_word(16'h0010)) begin
      failures++; $display("FAIL miss_data got=%h/%b exp=%h/1", ifid_instr, ifid_valid, mem_word(16'h0010)); end
    checks++; if (imem_addr !== 16'h0012 || ifid_pc_plus2 !== 16'h0012) begin
      failures++; $display("FAIL miss_pc got=%h/%h exp=0012/0012", imem_addr, ifid_pc_plus2); end
  endtask

  task automatic test_redirect_stall();
    do_reset(); lat_fix = 0;
    step();
    stall_id = 1; redirect_valid = 1; redirect_pc = 16'h0100;
    step();
    clear_inputs();
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
      failures++; $display("FAIL redir_stall_flush got=%h/%b exp=%h/0", ifid_instr, ifid_valid, NOP); end
    checks++; if (imem_addr !== 16'h0100) begin failures++; $display("FAIL redir_stall_addr got=%h exp=0100", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset(); lat_fix = 3;
    step();
    redirect_valid = 1; redirect_pc = 16'h0200; step();
    redirect_pc = 16'h0301; step();
    clear_inputs(); step();
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rwait_drop got=%b exp=0", ifid_valid); end
    checks++; if (imem_addr !== 16'h0300) begin failures++; $display("FAIL rwait_addr got=%h exp=0300", imem_addr); end
    lat_fix = 0; step();
    checks++; if (ifid_instr !== mem_word(16'h0300) || ifid_pc_plus2 !== 16'h0302) begin
      failures++; $display("FAIL rwait_next got=%h/%h exp=%h/0302", ifid_instr, ifid_pc_plus2, mem_word(16'h0300)); end
  endtask

  task automatic test_skid();
    do_reset(); lat_fix = 2;
    step();
    stall_id = 1; step(); step();
    checks++; if (imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL skid_hold got=%h/%b exp=0000/0", imem_addr, ifid_valid); end
    stall_id = 0; #1;
    checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL skid_rd got=%b exp=0", imem_rd); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== mem_word(16'h0000) || ifid_pc_plus2 !== 16'h0002) begin
      failures++; $display("FAIL skid_drain got=%h/%h/%b exp=%h/0002/1", ifid_instr, ifid_pc_plus2, ifid_valid, mem_word(16'h0000)); end
  endtask

  task automatic test_siic_rti();
    do_reset(); lat_fix = 0;
    stall_id = 1; redirect_valid = 1; redirect_pc = 16'h0500; step();
    clear_inputs(); step();
    siic_take = 1; siic_pc_plus2 = 16'h0044; step();
    clear_inputs();
    checks++; if (imem_addr !== 16'h0002 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL siic_vec got=%h/%b exp=0002/0", imem_addr, ifid_valid); end
    step(); step();
    rti_take = 1; step();
    clear_inputs();
    checks++; if (imem_addr !== 16'h0044) begin failures++; $display("FAIL rti_ret got=%h exp=0044", imem_addr); end
  endtask

  task automatic test_halt();
    logic [15:0] frozen;
    do_reset(); lat_fix = 0;
    step();
    halt_in = 1; step();
    halt_in = 0;
    frozen = imem_addr;
    checks++; if (fetch_halted !== 1'b1 || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL halt_enter got=%b/%b exp=1/0", fetch_halted, ifid_valid); end
    for (int k = 0; k < 20; k++) begin
      redirect_valid = 1'($urandom); redirect_pc = 16'($urandom);
      #1;
      checks++; if (imem_rd !== 1'b0 || fetch_halted !== 1'b1) begin
        failures++; $display("FAIL halt_hold%0d got=%b/%b exp=0/1", k, imem_rd, fetch_halted); end
      step();
    end
    clear_inputs();
    checks++; if (imem_addr !== frozen || ifid_valid !== 1'b0) begin
      failures++; $display("FAIL halt_frozen got=%h/%b exp=%h/0", imem_addr, ifid_valid, frozen); end
    do_reset(); step();
    halt_in = 1; redirect_valid = 1; redirect_pc = 16'h0080; step();
    clear_inputs();
    checks++; if (fetch_halted !== 1'b0 || imem_addr !== 16'h0080) begin
      failures++; $display("FAIL halt_wrongpath got=%b/%h exp=0/0080", fetch_halted, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    stall_id = 1; redirect_valid = 1; redirect_pc = 16'hFFFE; step();
    clear_inputs(); lat_fix = 0; step();
    checks++; if (imem_addr !== 16'h0000 || ifid_pc_plus2 !== 16'h0000 || ifid_instr !== mem_word(16'hFFFE)) begin
      failures++; $display("FAIL wrap got=%h/%h/%h exp=0000/0000/%h", imem_addr, ifid_pc_plus2, ifid_instr, mem_word(16'hFFFE)); end
  endtask

  task automatic test_reset_mid_miss();
    do_reset(); lat_fix = 2;
    step();
    rst = 1; stall_id = 1; step();
    rst = 0; step();
    checks++; if (ifid_valid !== 1'b0 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL stale_done got=%b/%h exp=0/0000", ifid_valid, imem_addr); end
    mbusy = 0; stall_id = 0; lat_fix = 0; step();
    checks++; if (ifid_instr !== mem_word(16'h0000) || ifid_pc_plus2 !== 16'h0002) begin
      failures++; $display("FAIL post_reset_fetch got=%h/%h exp=%h/0002", ifid_instr, ifid_pc_plus2, mem_word(16'h0000)); end
  endtask

  // Architectural model: the stream of valid IF/ID words is mem[exp_next], exp_next+2, ...
  // restarting at each redirect target; a stalled cycle leaves IF/ID untouched.
  task automatic test_random();
    logic [15:0] exp_next, exp_epc, p_i, p_p;
    logic p_v, hold;
    int loads, errs;
    do_reset(); lat_fix = -1;
    exp_next = 16'h0000; exp_epc = 16'h0000; loads = 0; errs = 0;
    for (int n = 0; n < 800; n++) begin
      stall_id       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 16'($urandom);
      siic_take      = ($urandom_range(0, 24) == 0);
      siic_pc_plus2  = 16'($urandom);
      rti_take       = ($urandom_range(0, 24) == 0);
      imem_stall     = !mbusy && ($urandom_range(0, 4) == 0);
      #1; mem_pre();
      if (imem_rd) begin
        checks++; if (imem_addr !== exp_next) begin
          failures++; errs++; if (errs < 10) $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem_addr, exp_next); end
      end
      p_i = ifid_instr; p_p = ifid_pc_plus2; p_v = ifid_valid;
      hold = stall_id && !(redirect_valid || siic_take || rti_take);
      @(posedge clk); mem_post();
      if (rti_take) exp_next = {exp_epc[15:1], 1'b0};
      else if (siic_take) begin exp_next = SIIC; exp_epc = siic_pc_plus2; end
      else if (redirect_valid) exp_next = {redirect_pc[15:1], 1'b0};
      @(negedge clk);
      checks++;
      if (hold) begin
        if ({ifid_instr, ifid_pc_plus2, ifid_valid} !== {p_i, p_p, p_v}) begin
          failures++; errs++; if (errs < 10) $display("FAIL rnd_hold n=%0d got=%h/%h/%b exp=%h/%h/%b", n, ifid_instr, ifid_pc_plus2, ifid_valid, p_i, p_p, p_v); end
      end else if (ifid_valid) begin
        if (ifid_instr !== mem_word(exp_next) || ifid_pc_plus2 !== 16'(exp_next + 16'd2)) begin
          failures++; errs++; if (errs < 10) $display("FAIL rnd_load n=%0d got=%h/%h exp=%h/%h", n, ifid_instr, ifid_pc_plus2, mem_word(exp_next), 16'(exp_next + 16'd2)); end
        exp_next = exp_next + 16'd2; loads++;
      end else if (ifid_instr !== NOP) begin
        failures++; errs++; if (errs < 10) $display("FAIL rnd_bubble n=%0d got=%h exp=%h", n, ifid_instr, NOP);
      end
    end
    clear_inputs();
    checks++; if (loads < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", loads); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1; imem_done = 1'b0; imem_data = 16'h0000;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_miss();
    test_redirect_stall();
    test_redirect_wait();
    test_skid();
    test_siic_rti();
    test_halt();
    test_wrap();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
